// File: rtl/nco_clk_enable_gen.sv
// rtl/nco_clk_enable_gen.sv - multi-channel NCO clock-enable generator with lock indication
module nco_clk_enable_gen #(
    parameter int                        CHANNELS    = 3,
    parameter int                        ACC_W       = 24,
    parameter logic [CHANNELS*ACC_W-1:0] INC_INIT    = {CHANNELS{ACC_W'(6291456)}},
    parameter int                        LOCK_CYCLES = 256,
    localparam int                       CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clkin,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_ch_en,
    input  logic                i_cfg_wr,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [ACC_W-1:0]    i_cfg_inc,
    output logic                o_cfg_ack,
    output logic [CHANNELS-1:0] o_ce_out,
    output logic [CHANNELS-1:0] o_sq_out,
    output logic                o_lock
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        ST_SETTLING,
        ST_LOCKED
    } lock_state_t;

    logic        w_wr_valid;
    lock_state_t r_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic        r_lock;
    logic        r_cfg_ack;

    // Writes to channel indices beyond CHANNELS are silently dropped.
    assign w_wr_valid = i_cfg_wr && (int'(i_cfg_ch) < CHANNELS);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_W-1:0] r_acc;
        logic [ACC_W-1:0] r_inc;
        logic             r_ce;
        logic [ACC_W:0]   w_sum;
        logic             w_hit;

        assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};
        assign w_hit = w_wr_valid && (int'(i_cfg_ch) == g);

        always_ff @(posedge i_clkin) begin
            if (i_reset) begin
                r_acc <= '0;
                r_inc <= INC_INIT[g*ACC_W +: ACC_W];
                r_ce  <= 1'b0;
            end else if (w_hit) begin
                // Phase reset on reprogramming so the new rate starts from a known edge.
                r_inc <= i_cfg_inc;
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (i_ch_en[g]) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W];
            end else begin
                r_ce  <= 1'b0;
            end
        end

        // Square output is the accumulator MSB, which already holds/clears with the accumulator.
        assign o_ce_out[g] = r_ce;
        assign o_sq_out[g] = r_acc[ACC_W-1];
    end

    always_ff @(posedge i_clkin) begin
        if (i_reset) begin
            r_state    <= ST_SETTLING;
            r_lock_cnt <= '0;
            r_lock     <= 1'b0;
            r_cfg_ack  <= 1'b0;
        end else begin
            r_cfg_ack <= w_wr_valid;
            if (w_wr_valid) begin
                r_state    <= ST_SETTLING;
                r_lock_cnt <= '0;
                r_lock     <= 1'b0;
            end else begin
                case (r_state)
                    ST_SETTLING: begin
                        if (r_lock_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                            r_lock  <= 1'b1;
                            r_state <= ST_LOCKED;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        r_lock <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_SETTLING;
                    end
                endcase
            end
        end
    end

    assign o_cfg_ack = r_cfg_ack;
    assign o_lock    = r_lock;

endmodule

// File: doc/nco_clk_enable_gen.md
Name: nco_clk_enable_gen

Overview:
- Parametrised successor to the fixed-ratio PLL clock wrapper.
- Generates CHANNELS independent fractional-rate clock enables and 50%-duty square outputs from one fabric clock.
- Each channel uses a phase accumulator (NCO). Ratios can be reprogrammed at runtime without re-synthesis.
- Provides a lock/settled indication and a config-write handshake. Sits after the board PLL and feeds video, CPU and sound clock-enable trees.

Parameters:
- CHANNELS, 3: number of independent NCO channels (1..8).
- ACC_W, 24: accumulator and increment width in bits. Output rate = f_clkin * inc / 2^ACC_W.
- INC_INIT, {CHANNELS{24'd6291456}}: packed per-channel reset increment, channel 0 in the LSBs. The default gives 10.125 MHz from 27 MHz.
- LOCK_CYCLES, 256: settle cycles after reset or after any accepted config write before lock asserts (>=1).

Ports:
- clkin  in  1  fabric clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_en  in  CHANNELS  per-channel run enable. Low freezes that accumulator.
- cfg_wr  in  1  config write strobe, single cycle.
- cfg_ch  in  max(1,clog2(CHANNELS))  target channel index.
- cfg_inc  in  ACC_W  new increment value.
- cfg_ack  out  1  one-cycle pulse when a write is accepted.
- ce_out  out  CHANNELS  one-cycle clock-enable pulse per accumulator overflow.
- sq_out  out  CHANNELS  square output, equal to the accumulator MSB.
- lock  out  1  high when all channels have been stable for LOCK_CYCLES.

Behaviour:
- Reset (synchronous, dominant over everything):
  - acc[i] = 0, inc[i] = INC_INIT[i].
  - ce_out = 0, sq_out = 0, cfg_ack = 0, lock = 0.
  - Lock counter = 0.
- Each rising edge, per channel i with ch_en[i] = 1:
  - {carry, acc[i]} <= acc[i] + inc[i], an (ACC_W+1)-bit sum. The accumulator wraps modulo 2^ACC_W.
  - ce_out[i] <= carry.
  - sq_out[i] <= MSB of the new acc[i].
  - Latency: ce_out is high in the cycle after the edge whose addition overflowed.
- ch_en[i] = 0: acc[i] holds, ce_out[i] <= 0, sq_out[i] holds.
- inc[i] = 0: the accumulator is stationary, ce_out[i] stays 0, sq_out[i] holds its MSB. This is not an error.
- Config write (cfg_wr = 1, cfg_ch < CHANNELS), at that edge:
  - inc[cfg_ch] <= cfg_inc.
  - acc[cfg_ch] <= 0 (phase reset). The normal add is suppressed that cycle.
  - ce_out[cfg_ch] <= 0.
  - sq_out[cfg_ch] <= 0.
  - cfg_ack <= 1 for exactly one cycle.
  - Lock counter <= 0 and lock <= 0.
  - Other channels continue unaffected.
- Invalid write (cfg_wr = 1, cfg_ch >= CHANNELS): ignored. No state change, no ack, lock unaffected.
- Back-to-back writes are accepted every cycle. Each write produces its own ack pulse and restarts the lock count.
- Lock state machine:
  - States: SETTLING, LOCKED.
  - SETTLING: the counter increments each cycle. When the counter reaches LOCK_CYCLES-1, lock <= 1 and the state moves to LOCKED. Lock is therefore first high exactly LOCK_CYCLES cycles after reset deassertion.
  - LOCKED: holds until reset or an accepted write, which return it to SETTLING with the counter at 0.
  - The counter saturates and never wraps.
  - ch_en does not affect lock.
- Reset mid-operation: all state returns to reset values on that edge, regardless of cfg_wr.
- Simultaneous cfg_wr and reset: reset wins, no ack.

Test Plan:
- Reset, then hold ch_en = 1 with the default increment of 6291456 -> ch0 gives exactly 3 ce_out pulses in every 8 cycles (the pattern repeats every 8 cycles); lock goes high on cycle 256 after reset release.
- Write ch1 inc = 0x800000 with ch_en = 111 -> cfg_ack pulses 1 cycle after the write; ce_out[1] pulses every 2nd cycle starting 2 cycles after the write; sq_out[1] toggles every cycle; ch0 and ch2 timing is unchanged.
- Write ch2 inc = 0 -> ce_out[2] stays 0 indefinitely; lock drops for exactly 256 cycles, then returns high.
- Drop ch_en[0] for 10 cycles mid-run -> no ce_out[0] pulses while low; pulse phase resumes shifted by 10 cycles; lock unaffected.
- cfg_wr with cfg_ch = 3 (CHANNELS = 3) -> no cfg_ack, no state change, lock stays high.
- Assert reset together with cfg_wr while locked -> all outputs 0 next cycle; inc returns to INC_INIT; no ack; lock re-asserts after 256 cycles.
